// File: rtl/imem_loader.sv
// Instruction-memory loader: header byte N, then N little-endian words written to words 0..N-1; the core is held in reset until the load finishes.
// Latency: one write cycle after each 4th data byte, so at least 5 cycles per word. in_ready is low in WRITE, DONE and ERROR, and the source holds its byte.
// Optional IMEM_LOADER_CHECKSUM_EN: a trailing byte must equal the XOR of the header and data bytes.
module imem_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              core_rst_n,
    input  logic              restart
);
    localparam int DEPTH = 2**ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_HDR, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERROR} state_t;
`else
    typedef enum logic [2:0] {S_HDR, S_DATA, S_WRITE, S_DONE, S_ERROR} state_t;
`endif

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   last_q, last_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [1:0]          bcnt_q, bcnt_d;
    logic [31:0]         shift_q, shift_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [31:0]         wr_data_q, wr_data_d;
    logic                accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          csum_q, csum_d;
`endif

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign in_ready   = rst_n && (state_q == S_HDR || state_q == S_DATA || state_q == S_CSUM);
    assign busy       = (state_q == S_DATA || state_q == S_WRITE || state_q == S_CSUM);
`else
    assign in_ready   = rst_n && (state_q == S_HDR || state_q == S_DATA);
    assign busy       = (state_q == S_DATA || state_q == S_WRITE);
`endif
    assign accept     = in_valid && in_ready;
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERROR);
    assign core_rst_n = (state_q == S_DONE);
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        idx_d     = idx_q;
        bcnt_d    = bcnt_q;
        shift_d   = shift_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        case (state_q)
            S_HDR: begin
                if (accept) begin
                    if ({24'd0, in_data} > 32'(DEPTH)) begin
                        state_d = S_ERROR;
                    end else begin
                        // N=0 wraps to DEPTH-1 in the truncation, which is exactly a full load
                        last_d  = ADDR_W'(in_data - 8'd1);
                        idx_d   = '0;
                        bcnt_d  = '0;
                        state_d = S_DATA;
                    end
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d = in_data;
`endif
                end
            end
            S_DATA: begin
                if (accept) begin
                    shift_d = {in_data, shift_q[31:8]};
                    bcnt_d  = bcnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ in_data;
`endif
                    if (bcnt_q == 2'd3) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = idx_q;
                        wr_data_d = {in_data, shift_q[31:8]};
                        state_d   = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (idx_q == last_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_DATA;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept) begin
                    state_d = (in_data == csum_q) ? S_DONE : S_ERROR;
                end
            end
`endif
            S_DONE, S_ERROR: begin
                if (restart) begin
                    state_d = S_HDR;
                end
            end
            default: state_d = S_HDR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_HDR;
            last_q    <= '0;
            idx_q     <= '0;
            bcnt_q    <= '0;
            shift_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            idx_q     <= idx_d;
            bcnt_q    <= bcnt_d;
            shift_q   <= shift_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed vector table, hand-written corner sequences and random loads against a stream-level model.
module tb_imem_loader;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          restart = 1'b0;
    logic          in_ready, wr_en, busy, done, error, core_rst_n;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;

    imem_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .error(error), .core_rst_n(core_rst_n),
        .restart(restart)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0]  stim_q[$];
    logic [37:0] obs_q[$];
    logic [37:0] exp_q[$];
    logic        exp_done, exp_err;
    logic        prev_wr = 1'b0;
    logic        done_after_wr = 1'b0;
    logic        busy_after_wr = 1'b0;

    typedef struct {
        int           len;
        logic [127:0] b;
        logic         ok;
        int           nwr;
        logic [31:0]  w0;
        logic [31:0]  wl;
    } vec_t;
    vec_t vecs[5];

    always @(negedge clk) begin
        if (prev_wr) begin
            done_after_wr = done;
            busy_after_wr = busy;
        end
        prev_wr = wr_en;
        if (wr_en) obs_q.push_back({wr_addr, wr_data});
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    function automatic logic [7:0] xor_all();
        logic [7:0] x = 8'h00;
        foreach (stim_q[i]) x ^= stim_q[i];
        return x;
    endfunction

    // Stream-level model: parse header, assemble LE words, judge the trailing checksum.
    task automatic model_load();
        int n, words;
        logic [7:0] x;
        exp_q.delete();
        n = int'(stim_q[0]);
        if (n > DEPTH) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
            return;
        end
        words = (n == 0) ? DEPTH : n;
        x = stim_q[0];
        for (int w = 0; w < words; w++) begin
            logic [31:0] d;
            d = 32'(stim_q[1+4*w]) + (32'(stim_q[2+4*w]) << 8)
              + (32'(stim_q[3+4*w]) << 16) + (32'(stim_q[4+4*w]) << 24);
            x = x ^ stim_q[1+4*w] ^ stim_q[2+4*w] ^ stim_q[3+4*w] ^ stim_q[4+4*w];
            exp_q.push_back({AW'(w), d});
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        exp_done = (stim_q[1+4*words] == x);
`else
        exp_done = 1'b1;
`endif
        exp_err = !exp_done;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int g = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            chk("handshake_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_restart(input string tag);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk({tag, "_rst_done"}, 64'(done), 64'd0);
        chk({tag, "_rst_error"}, 64'(error), 64'd0);
        chk({tag, "_rst_core"}, 64'(core_rst_n), 64'd0);
        chk({tag, "_rst_ready"}, 64'(in_ready), 64'd1);
    endtask

    task automatic wait_end();
        int g = 0;
        while (!(done || error) && g < 20) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
    endtask

    task automatic run_load(input string tag);
        model_load();
        obs_q.delete();
        foreach (stim_q[i]) send_byte(stim_q[i]);
        wait_end();
        chk({tag, "_done"}, 64'(done), 64'(exp_done));
        chk({tag, "_error"}, 64'(error), 64'(exp_err));
        chk({tag, "_core_rst_n"}, 64'(core_rst_n), 64'(exp_done));
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_nwr"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk($sformatf("%s_wr%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (obs_q.size() > 0) chk({tag, "_csum_wait"}, 64'(busy_after_wr), 64'd1);
`else
        if (exp_done && obs_q.size() > 0) chk({tag, "_done_next"}, 64'(done_after_wr), 64'd1);
`endif
        do_restart(tag);
    endtask

    initial begin
        vecs[0] = '{9,  128'h02_13_23_00_00_93_00_10_00_00_00_00_00_00_00_00, 1'b1, 2, 32'h00002313, 32'h00100093};
        vecs[1] = '{1,  128'h41_00_00_00_00_00_00_00_00_00_00_00_00_00_00_00, 1'b0, 0, 32'h0, 32'h0};
        vecs[2] = '{1,  128'hFF_00_00_00_00_00_00_00_00_00_00_00_00_00_00_00, 1'b0, 0, 32'h0, 32'h0};
        vecs[3] = '{5,  128'h01_EF_BE_AD_DE_00_00_00_00_00_00_00_00_00_00_00, 1'b1, 1, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[4] = '{13, 128'h03_11_22_33_44_55_66_77_88_99_AA_BB_CC_00_00_00, 1'b1, 3, 32'h44332211, 32'hCCBBAA99};

        // reset state, with a source already offering a byte
        in_valid = 1'b1;
        in_data  = 8'h41;
        @(negedge clk);
        @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        chk("reset_wr_en", 64'(wr_en), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_error", 64'(error), 64'd0);
        chk("reset_wr_addr", 64'(wr_addr), 64'd0);
        chk("reset_wr_data", 64'(wr_data), 64'd0);
        chk("reset_core_rst_n", 64'(core_rst_n), 64'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("hdr_in_ready", 64'(in_ready), 64'd1);

        for (int v = 0; v < 5; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            stim_q.delete();
            for (int i = 0; i < vecs[v].len; i++) stim_q.push_back(vecs[v].b[127-8*i -: 8]);
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (vecs[v].ok) stim_q.push_back(xor_all());
`endif
            run_load(tag);
            chk({tag, "_tbl_ok"}, 64'(exp_done), 64'(vecs[v].ok));
            chk({tag, "_tbl_nwr"}, 64'(obs_q.size()), 64'(vecs[v].nwr));
            if (vecs[v].nwr > 0) begin
                if (obs_q.size() > 0) begin
                    chk({tag, "_tbl_w0"}, 64'(obs_q[0][31:0]), 64'(vecs[v].w0));
                    chk({tag, "_tbl_wl"}, 64'(obs_q[obs_q.size()-1][31:0]), 64'(vecs[v].wl));
                end else begin
                    chk({tag, "_tbl_have_wr"}, 64'(obs_q.size()), 64'(vecs[v].nwr));
                end
            end
        end

        // backpressure: 0xAA offered during WRITE must not be consumed there
        begin
            logic [7:0] bp[10];
            logic [7:0] x;
            bp = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
            x = 8'h00;
            for (int i = 0; i < 9; i++) x ^= bp[i];
            obs_q.delete();
            for (int i = 0; i < 5; i++) send_byte(bp[i]);
            in_valid = 1'b1;
            in_data  = 8'hAA;
            chk("bp_write_wr_en", 64'(wr_en), 64'd1);
            chk("bp_write_in_ready", 64'(in_ready), 64'd0);
            chk("bp_write_data", 64'(wr_data), 64'h44332211);
            @(negedge clk);
            chk("bp_after_in_ready", 64'(in_ready), 64'd1);
            chk("bp_after_wr_en", 64'(wr_en), 64'd0);
            for (int i = 5; i < 9; i++) send_byte(bp[i]);
`ifdef IMEM_LOADER_CHECKSUM_EN
            send_byte(x);
`endif
            wait_end();
            chk("bp_done", 64'(done), 64'd1);
            chk("bp_nwr", 64'(obs_q.size()), 64'd2);
            if (obs_q.size() == 2)
                chk("bp_word1", 64'(obs_q[1]), 64'({6'd1, 32'hDDCCBBAA}));
            do_restart("bp");
        end

        // full-depth loads: header 0x00 and header 0x40
        for (int h = 0; h < 2; h++) begin
            stim_q.delete();
            stim_q.push_back(h == 0 ? 8'h00 : 8'h40);
            for (int i = 0; i < 4*DEPTH; i++) stim_q.push_back(8'($urandom));
`ifdef IMEM_LOADER_CHECKSUM_EN
            stim_q.push_back(xor_all());
`endif
            run_load($sformatf("full%0d", h));
            chk($sformatf("full%0d_count", h), 64'(obs_q.size()), 64'd64);
            if (obs_q.size() == 64)
                chk($sformatf("full%0d_last_addr", h), 64'(obs_q[63][37:32]), 64'd63);
        end

        // random loads, including oversize headers
        for (int r = 0; r < 8; r++) begin
            int n, words;
            n = int'($urandom_range(0, 72));
            stim_q.delete();
            stim_q.push_back(8'(n));
            if (n <= DEPTH) begin
                words = (n == 0) ? DEPTH : n;
                for (int i = 0; i < 4*words; i++) stim_q.push_back(8'($urandom));
`ifdef IMEM_LOADER_CHECKSUM_EN
                stim_q.push_back(($urandom_range(0, 3) == 0) ? (xor_all() ^ 8'h01) : xor_all());
`endif
            end
            run_load($sformatf("rand%0d", r));
        end

        // reset in the middle of a word
        send_byte(8'h02);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_wr_data", 64'(wr_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        stim_q = '{8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef IMEM_LOADER_CHECKSUM_EN
        stim_q.push_back(xor_all());
`endif
        run_load("midrst");
        chk("midrst_nwr", 64'(obs_q.size()), 64'd1);
        if (obs_q.size() == 1) chk("midrst_word", 64'(obs_q[0]), 64'({6'd0, 32'hDEADBEEF}));

`ifdef IMEM_LOADER_CHECKSUM_EN
        stim_q = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        run_load("csum_good");
        chk("csum_good_model", 64'(exp_done), 64'd1);
        stim_q = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h06};
        run_load("csum_bad");
        chk("csum_bad_model", 64'(exp_err), 64'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
